// File: rtl/ex_stage_pipe_if.sv
// ex_stage_pipe_if: decode-side inputs, forwarding inputs and MEM-side outputs
// of the execute stage bundled into one interface. The stage uses the slave
// view; whatever drives decode/forwarding and consumes results uses master.
interface ex_stage_pipe_if #(
  parameter int DW   = 32,
  parameter int CW   = 16,
  parameter int NFWD = 2,
  parameter int SW   = $clog2(NFWD + 1)
);
  logic               in_valid;
  logic [CW-1:0]      in_ctrl;
  logic               in_regwr;
  logic [3:0]         in_alu_ctrl;
  logic               in_alu_src;
  logic [DW-1:0]      in_busA;
  logic [DW-1:0]      in_busB;
  logic [DW-1:0]      in_imm;
  logic [4:0]         in_rw;
  logic               stall_in;
  logic               flush;
  logic [SW-1:0]      selA;
  logic [SW-1:0]      selB;
  logic [NFWD*DW-1:0] fwd_data;

  logic               ex_busy;
  logic               out_valid;
  logic [CW-1:0]      out_ctrl;
  logic               out_regwr;
  logic [4:0]         out_rw;
  logic [DW-1:0]      alu_out;
  logic [DW-1:0]      store_data;
  logic               out_ovf;

  modport master (
    output in_valid, in_ctrl, in_regwr, in_alu_ctrl, in_alu_src,
    output in_busA, in_busB, in_imm, in_rw, stall_in, flush,
    output selA, selB, fwd_data,
    input  ex_busy, out_valid, out_ctrl, out_regwr, out_rw,
    input  alu_out, store_data, out_ovf
  );

  modport slave (
    input  in_valid, in_ctrl, in_regwr, in_alu_ctrl, in_alu_src,
    input  in_busA, in_busB, in_imm, in_rw, stall_in, flush,
    input  selA, selB, fwd_data,
    output ex_busy, out_valid, out_ctrl, out_regwr, out_rw,
    output alu_out, store_data, out_ovf
  );
endinterface

// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: ID/EX register, N-source operand forwarding, single-cycle ALU
// and a shift-add iterative multiplier that back-pressures decode via ex_busy.
// Optional feature: define EX_OVF_TRAP_EN to flag signed ADD/SUB overflow on
// out_ovf and suppress the register write of the overflowing instruction.
//
// MUL FSM states:
//   state | meaning
//   IDLE  | no multiply in flight; a MUL sitting in the stage starts here
//   BUSY  | one shift-add step per cycle, DW steps
//   DONE  | product held on alu_out with out_valid until downstream takes it
module ex_stage_pipe #(
  parameter int DW   = 32,
  parameter int CW   = 16,
  parameter int NFWD = 2
) (
  input logic            clk,
  input logic            rst_n,
  ex_stage_pipe_if.slave bus
);
  localparam int SW   = $clog2(NFWD + 1);
  localparam int SHW  = $clog2(DW);
  localparam int CNTW = $clog2(DW);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_t;

  logic            r_valid;
  logic [CW-1:0]   r_ctrl;
  logic            r_regwr;
  logic [3:0]      r_alu_ctrl;
  logic            r_alu_src;
  logic [DW-1:0]   r_a;
  logic [DW-1:0]   r_b;
  logic [DW-1:0]   r_imm;
  logic [4:0]      r_rw;

  mul_state_t      mul_state;
  logic [DW-1:0]   mcand;
  logic [DW-1:0]   mplier;
  logic [DW-1:0]   acc;
  logic [CNTW-1:0] cnt;

  logic [DW-1:0]   op_a;
  logic [DW-1:0]   f_b;
  logic [DW-1:0]   op_b;
  logic [DW-1:0]   alu_res;
  logic [SHW-1:0]  shamt;
  logic            is_mul;
  logic            busy;
  logic            out_valid;

  assign is_mul    = r_valid && (r_alu_ctrl == 4'd12);
  assign busy      = is_mul && (mul_state != ST_DONE);
  assign out_valid = r_valid && !busy;

  // Stage register: flush empties it, stall or a running MUL freezes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_ctrl     <= '0;
      r_regwr    <= 1'b0;
      r_alu_ctrl <= '0;
      r_alu_src  <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_imm      <= '0;
      r_rw       <= '0;
    end else if (bus.flush) begin
      r_valid    <= 1'b0;
      r_ctrl     <= '0;
      r_regwr    <= 1'b0;
      r_alu_ctrl <= '0;
      r_alu_src  <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_imm      <= '0;
      r_rw       <= '0;
    end else if (!(bus.stall_in || busy)) begin
      r_valid    <= bus.in_valid;
      r_ctrl     <= bus.in_ctrl;
      r_regwr    <= bus.in_regwr;
      r_alu_ctrl <= bus.in_alu_ctrl;
      r_alu_src  <= bus.in_alu_src;
      r_a        <= bus.in_busA;
      r_b        <= bus.in_busB;
      r_imm      <= bus.in_imm;
      r_rw       <= bus.in_rw;
    end
  end

  // Operand forwarding: 0 picks the stage register, k picks slot k-1, and any
  // select beyond the last slot yields zero.
  always_comb begin
    op_a = '0;
    f_b  = '0;
    if (bus.selA == '0) op_a = r_a;
    if (bus.selB == '0) f_b  = r_b;
    for (int k = 0; k < NFWD; k++) begin
      if (bus.selA == SW'(k + 1)) op_a = bus.fwd_data[k*DW +: DW];
      if (bus.selB == SW'(k + 1)) f_b  = bus.fwd_data[k*DW +: DW];
    end
  end

  assign op_b  = r_alu_src ? r_imm : f_b;
  assign shamt = op_b[SHW-1:0];

  // Single-cycle ALU; MUL goes through the iterative unit, so 12 reads 0 here.
  always_comb begin
    alu_res = '0;
    case (r_alu_ctrl)
      4'd0:    alu_res = op_a + op_b;
      4'd1:    alu_res = op_a - op_b;
      4'd2:    alu_res = op_a & op_b;
      4'd3:    alu_res = op_a | op_b;
      4'd4:    alu_res = op_a ^ op_b;
      4'd5:    alu_res = ~(op_a | op_b);
      4'd6:    alu_res = {{(DW-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'd7:    alu_res = {{(DW-1){1'b0}}, (op_a < op_b)};
      4'd8:    alu_res = op_a << shamt;
      4'd9:    alu_res = op_a >> shamt;
      4'd10:   alu_res = $unsigned($signed(op_a) >>> shamt);
      4'd11:   alu_res = op_b << (DW / 2);
      default: alu_res = '0;
    endcase
  end

  // MUL sequencer: operands are latched on the IDLE->BUSY edge so forwarding
  // selects only matter for that one cycle; flush aborts from any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_state <= ST_IDLE;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else if (bus.flush) begin
      mul_state <= ST_IDLE;
    end else begin
      case (mul_state)
        ST_IDLE: begin
          if (is_mul) begin
            mul_state <= ST_BUSY;
            mcand     <= op_a;
            mplier    <= op_b;
            acc       <= '0;
            cnt       <= '0;
          end
        end
        ST_BUSY: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CNTW'(DW - 1)) mul_state <= ST_DONE;
        end
        ST_DONE: begin
          if (!bus.stall_in) mul_state <= ST_IDLE;
        end
        default: mul_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ex_busy    = busy;
  assign bus.out_valid  = out_valid;
  assign bus.out_ctrl   = r_ctrl;
  assign bus.out_rw     = r_rw;
  assign bus.alu_out    = (mul_state == ST_DONE) ? acc : alu_res;
  assign bus.store_data = f_b;

`ifdef EX_OVF_TRAP_EN
  logic ovf;

  // Signed overflow: ADD when operands agree in sign and the sum does not,
  // SUB when operands differ in sign and the result leaves op_a's sign.
  always_comb begin
    ovf = 1'b0;
    if (r_alu_ctrl == 4'd0)
      ovf = (op_a[DW-1] == op_b[DW-1]) && (alu_res[DW-1] != op_a[DW-1]);
    else if (r_alu_ctrl == 4'd1)
      ovf = (op_a[DW-1] != op_b[DW-1]) && (alu_res[DW-1] != op_a[DW-1]);
  end

  assign bus.out_ovf   = ovf && out_valid;
  assign bus.out_regwr = r_valid && r_regwr && !ovf;
`else
  assign bus.out_ovf   = 1'b0;
  assign bus.out_regwr = r_valid && r_regwr;
`endif

endmodule
